// File: rtl/sha256_msg_padder_if.sv
// rtl/sha256_msg_padder_if.sv - message memory read bus and padded block stream of the SHA-256 padder
interface sha256_msg_padder_if;
    logic         mem_clk;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_read_data;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_last;
    logic [7:0]   blk_idx;

    modport master (
        output mem_clk, mem_we, mem_addr,
        input  mem_read_data,
        output blk_valid, blk_data, blk_last, blk_idx,
        input  blk_ready
    );

    modport slave (
        input  mem_clk, mem_we, mem_addr,
        output mem_read_data,
        input  blk_valid, blk_data, blk_last, blk_idx,
        output blk_ready
    );
endinterface

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - SHA-256 message fetch and padding into 512-bit blocks; SHA256_PAD_BSWAP_EN byte-reverses fetched words
module sha256_msg_padder #(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] message_addr,
    output logic        done,
    sha256_msg_padder_if.master bus
);
    localparam int          NBLK    = (NUM_OF_WORDS + 2) / 16 + 1;
    localparam logic [63:0] BIT_LEN = 64'(NUM_OF_WORDS) * 64'd32;

    typedef enum logic [1:0] {IDLE, FETCH, PAD, OFFER} state_t;

    state_t            state, state_nxt;
    logic [7:0]        blk;
    logic [4:0]        k;
    logic [15:0]       base;
    logic [15:0]       mem_addr_q;
    logic              pad_hold;
    logic [0:15][31:0] words;
    logic [4:0]        m_cur, m_nxt;
    logic              last_blk, handshake;

    // Message words that fall inside block b, clamped to 0..16.
    function automatic logic [4:0] words_in_block(input logic [7:0] b);
        int rem;
        rem = NUM_OF_WORDS - 16 * int'(b);
        if (rem <= 0)       return 5'd0;
        else if (rem >= 16) return 5'd16;
        else                return 5'(rem);
    endfunction

    function automatic logic [31:0] store_word(input logic [31:0] d);
`ifdef SHA256_PAD_BSWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    // Content of a non-message word at global index g, position j of its block.
    function automatic logic [31:0] pad_word(input int g, input int j, input logic last);
        if (g == NUM_OF_WORDS)  return 32'h8000_0000;
        if (last && j == 14)    return BIT_LEN[63:32];
        if (last && j == 15)    return BIT_LEN[31:0];
        return 32'h0;
    endfunction

    assign m_cur     = words_in_block(blk);
    assign m_nxt     = words_in_block(blk + 8'd1);
    assign last_blk  = (blk == 8'(NBLK - 1));
    assign handshake = (state == OFFER) && bus.blk_ready;

    assign bus.mem_clk   = clk;
    assign bus.mem_we    = 1'b0;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.blk_valid = (state == OFFER);
    assign bus.blk_data  = words;
    assign bus.blk_last  = (state == OFFER) && last_blk;
    assign bus.blk_idx   = blk;
    assign done          = (state == IDLE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = FETCH;
            FETCH: if (k == m_cur) state_nxt = PAD;
            PAD:   if (!pad_hold) state_nxt = OFFER;
            OFFER: if (handshake) begin
                if (last_blk)          state_nxt = IDLE;
                else if (m_nxt != 5'd0) state_nxt = FETCH;
                else                   state_nxt = PAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Fetch addressing, word capture and padding; with no words to fetch,
    // PAD holds one extra cycle so block latency stays m+2 regardless of m.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk        <= 8'd0;
            k          <= 5'd0;
            base       <= 16'd0;
            mem_addr_q <= 16'd0;
            pad_hold   <= 1'b0;
            words      <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    blk        <= 8'd0;
                    k          <= 5'd0;
                    base       <= message_addr;
                    mem_addr_q <= message_addr;
                    pad_hold   <= 1'b0;
                end
                FETCH: begin
                    if (k != 5'd0) words[4'(k - 5'd1)] <= store_word(bus.mem_read_data);
                    if (k + 5'd1 < m_cur) mem_addr_q <= mem_addr_q + 16'd1;
                    k <= k + 5'd1;
                end
                PAD: begin
                    pad_hold <= 1'b0;
                    for (int j = 0; j < 16; j++) begin
                        if (16 * int'(blk) + j >= NUM_OF_WORDS)
                            words[j] <= pad_word(16 * int'(blk) + j, j, last_blk);
                    end
                end
                OFFER: if (handshake && !last_blk) begin
                    blk      <= blk + 8'd1;
                    k        <= 5'd0;
                    pad_hold <= (m_nxt == 5'd0);
                    if (m_nxt != 5'd0) mem_addr_q <= base + 16'({blk + 8'd1, 4'h0});
                end
                default: ;
            endcase
        end
    end
endmodule
